fire_pulse_monitor: RTL and testbench
=====================================

# fire_pulse_monitor

Receive-side companion to the trigger authorizer: consumes the single-cycle `enable_fire` authorization pulse, verifies it against protocol rules, and converts each legal pulse into a request/done handshake toward the downstream actuator interface. Enforces a minimum spacing between accepted authorizations. Latches a sticky, coded fault on any protocol violation; only an explicit clear exits the fault. Sits between the authorizer and the actuator driver, and acts as an independent safety interlock.

## Interface
- `HOLDOFF_CYCLES`, 1000: cycles after a completed handshake during which no new pulse is legal.
- `ACK_TIMEOUT`, 256: maximum cycles from `act_req` rise to `act_done`.
- `CNT_W`, 16: width of the accepted-command counter.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `enable_fire`  in  1  authorization pulse; legal only as a 1-cycle pulse.
- `manual_lock`  in  1  same manual lock level that feeds the authorizer.
- `act_done`  in  1  actuator completion; sampled only while `act_req`=1.
- `fault_clr`  in  1  clears FAULT; ignored in every other state.
- `act_req`  out  1  registered request; held until `act_done` is sampled.
- `busy`  out  1  high in REQ or HOLDOFF.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  3  first fault cause: 0 none, 1 pulse while locked, 2 width violation, 3 early pulse, 4 ack timeout, 5 spurious done, 6 lock during request.
- `cmd_count`  out  CNT_W  count of accepted pulses.

## Operation
- States: IDLE, REQ, HOLDOFF, FAULT. Reset enters IDLE.
- IDLE to REQ: `enable_fire`=1, `manual_lock`=0, and the previous-cycle `enable_fire`=0. This increments `cmd_count`, which wraps modulo 2^CNT_W.
- REQ to HOLDOFF: `act_done`=1. This loads the timer with HOLDOFF_CYCLES-1.
- HOLDOFF to IDLE: the timer reaches 0.
- Any state except FAULT to FAULT, on these violations:
  - `enable_fire` while `manual_lock`=1 gives code 1.
  - `enable_fire` high on two consecutive cycles gives code 2.
  - `enable_fire` in REQ or HOLDOFF gives code 3.
  - Timer expiry in REQ gives code 4.
  - `act_done` in IDLE or HOLDOFF gives code 5.
  - `manual_lock` rising in REQ gives code 6.
- Priority when violations coincide in one cycle: 6 > 1 > 2 > 3 > 4 > 5.
- Once in FAULT, `fault_code` holds the first cause; later violations do not overwrite it.
- FAULT to IDLE: `fault_clr`=1 AND `enable_fire`=0 AND `manual_lock`=0 on the same cycle. This also zeroes `fault_code`. `cmd_count` is not cleared.
- In FAULT, `act_req`=0 and no pulse is accepted.
- `manual_lock` held in IDLE or HOLDOFF is not a fault. It only blocks acceptance, and an `enable_fire` pulse while it is held raises code 1.

## Timing
- Reset values: `act_req`=0, `busy`=0, `fault`=0, `fault_code`=0, `cmd_count`=0; timer=0; previous-`enable_fire` register=0.
- Pulse sampled at edge N gives `act_req`=1 and `busy`=1 at N+1.
- `act_done` sampled at edge M gives `act_req`=0 at M+1, and HOLDOFF lasts exactly HOLDOFF_CYCLES cycles. `act_done` coincident with the request's first cycle is legal.
- Timeout: if `act_done` has not been sampled by the ACK_TIMEOUT-th cycle of `act_req` high, FAULT is taken on the next edge. `act_done` arriving on that ACK_TIMEOUT-th cycle is legal.
- A fault detected at edge K gives `fault`=1, `act_req`=0 and valid `fault_code` at K+1.
- Width violation: a pulse accepted at N and still high at N+1 produces a 1-cycle `act_req` glitch at N+1, then FAULT at N+2. This is required behaviour.
- Reset assertion mid-REQ drops `act_req` immediately (asynchronous reset).

## Configuration
- `FIRE_MON_COUNTER_EN` defined: `cmd_count` is implemented as described.
- Not defined: `cmd_count` is tied to 0 and no counter flops are inferred. All other behaviour is identical.

## Structure
- `fire_mon_pkg` holds the state encoding (2-bit enum), the fault-code localparams 0–6, and defaults for HOLDOFF_CYCLES and ACK_TIMEOUT.
- One sub-module, `fire_mon_timer`: a loadable down-counter with a `zero` flag. It is shared between the ack timeout and the holdoff, and sized as clog2 of max(HOLDOFF_CYCLES, ACK_TIMEOUT).

## Test plan
The bench uses HOLDOFF_CYCLES=8, ACK_TIMEOUT=4, CNT_W=4 and `FIRE_MON_COUNTER_EN` defined.
- Legal pulse at cycle 10, `act_done` at cycle 12: `act_req` is high in cycles 11–12, `busy` is low from cycle 21, and `cmd_count`=1.
- Second pulse 3 cycles after `act_done` (during HOLDOFF): `fault`=1 with `fault_code`=3. `fault_clr` with lock low returns to IDLE; `cmd_count` stays 1.
- 2-cycle `enable_fire` pulse: `act_req` is high for 1 cycle, then `fault_code`=2.
- Request with no `act_done`: FAULT with `fault_code`=4 on the 5th cycle after `act_req` rise, and `act_req`=0 thereafter.
- `manual_lock` and `enable_fire` both rise in REQ on the same cycle: `fault_code`=6, not 3. A later `act_done` in FAULT does not change the code.
- 17 legal handshakes: `cmd_count` wraps to 1. `rst_n` pulsed low mid-REQ drops `act_req` asynchronously and all outputs read 0.

Source files
------------

// File: rtl/fire_mon_pkg.sv
// rtl/fire_mon_pkg.sv - state encoding, fault codes and defaults for fire_pulse_monitor
package fire_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_LOCKED   = 3'd1;
    localparam logic [2:0] FC_WIDTH    = 3'd2;
    localparam logic [2:0] FC_EARLY    = 3'd3;
    localparam logic [2:0] FC_TIMEOUT  = 3'd4;
    localparam logic [2:0] FC_SPURIOUS = 3'd5;
    localparam logic [2:0] FC_LOCK_REQ = 3'd6;

    localparam int DEF_HOLDOFF_CYCLES = 1000;
    localparam int DEF_ACK_TIMEOUT    = 256;

    // Coincident violations resolve to a single code, most safety-relevant first.
    function automatic logic [2:0] pick_fault(
        input logic lock_rise_req,
        input logic locked_pulse,
        input logic width_viol,
        input logic early_pulse,
        input logic ack_timeout,
        input logic spurious_done
    );
        logic [2:0] code;
        code = FC_NONE;
        if (lock_rise_req)      code = FC_LOCK_REQ;
        else if (locked_pulse)  code = FC_LOCKED;
        else if (width_viol)    code = FC_WIDTH;
        else if (early_pulse)   code = FC_EARLY;
        else if (ack_timeout)   code = FC_TIMEOUT;
        else if (spurious_done) code = FC_SPURIOUS;
        return code;
    endfunction

endpackage

// File: rtl/fire_mon_timer.sv
// rtl/fire_mon_timer.sv - loadable down-counter shared by ack timeout and holdoff
module fire_mon_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Counts down and parks at zero until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/fire_pulse_monitor.sv
// rtl/fire_pulse_monitor.sv - enable_fire protocol checker and actuator handshake; FIRE_MON_COUNTER_EN enables cmd_count
module fire_pulse_monitor
    import fire_mon_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int ACK_TIMEOUT    = DEF_ACK_TIMEOUT,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_fire,
    input  logic             manual_lock,
    input  logic             act_done,
    input  logic             fault_clr,
    output logic             act_req,
    output logic             busy,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] cmd_count
);

    localparam int TMR_MAX = (HOLDOFF_CYCLES > ACK_TIMEOUT) ? HOLDOFF_CYCLES : ACK_TIMEOUT;
    localparam int TMR_W   = ($clog2(TMR_MAX) > 0) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] ACK_LOAD  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLDOFF_CYCLES - 1);

    state_t             state_q;
    state_t             next_state;
    logic               prev_ef_q;
    logic               prev_lock_q;
    logic [2:0]         fault_code_q;
    logic [2:0]         viol_code;
    logic               in_req;
    logic               in_hold;
    logic               in_fault;
    logic               accept;
    logic               load_hold;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_load_val;
    logic               tmr_zero;

    assign in_req   = (state_q == ST_REQ);
    assign in_hold  = (state_q == ST_HOLDOFF);
    assign in_fault = (state_q == ST_FAULT);

    assign viol_code = in_fault ? FC_NONE : pick_fault(
        in_req && manual_lock && !prev_lock_q,
        enable_fire && manual_lock,
        enable_fire && prev_ef_q,
        enable_fire && (in_req || in_hold),
        in_req && tmr_zero && !act_done,
        act_done && !in_req
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prev_ef_q   <= 1'b0;
            prev_lock_q <= 1'b0;
        end else begin
            state_q     <= next_state;
            prev_ef_q   <= enable_fire;
            prev_lock_q <= manual_lock;
        end
    end

    // Any violation outranks the normal transition out of the current state.
    always_comb begin
        next_state = state_q;
        accept     = 1'b0;
        load_hold  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (viol_code != FC_NONE) begin
                    next_state = ST_FAULT;
                end else if (enable_fire) begin
                    accept     = 1'b1;
                    next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (viol_code != FC_NONE) begin
                    next_state = ST_FAULT;
                end else if (act_done) begin
                    load_hold  = 1'b1;
                    next_state = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (viol_code != FC_NONE) begin
                    next_state = ST_FAULT;
                end else if (tmr_zero) begin
                    next_state = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !enable_fire && !manual_lock) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        act_req = 1'b0;
        busy    = 1'b0;
        fault   = 1'b0;
        case (state_q)
            ST_REQ: begin
                act_req = 1'b1;
                busy    = 1'b1;
            end
            ST_HOLDOFF: busy  = 1'b1;
            ST_FAULT:   fault = 1'b1;
            default: ;
        endcase
    end

    // Only the first cause is captured; the code is frozen while faulted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_code_q <= FC_NONE;
        end else if (!in_fault && next_state == ST_FAULT) begin
            fault_code_q <= viol_code;
        end else if (in_fault && next_state == ST_IDLE) begin
            fault_code_q <= FC_NONE;
        end
    end

    assign fault_code = fault_code_q;

    assign tmr_load     = accept || load_hold;
    assign tmr_load_val = load_hold ? HOLD_LOAD : ACK_LOAD;

    fire_mon_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .zero     (tmr_zero)
    );

`ifdef FIRE_MON_COUNTER_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cmd_count = cnt_q;
`else
    assign cmd_count = '0;
`endif

endmodule

// File: tb/tb_fire_pulse_monitor.sv
// tb/tb_fire_pulse_monitor.sv - directed and randomized checks of fire_pulse_monitor against a behavioural model
module tb_fire_pulse_monitor;

    localparam int H = 8;
    localparam int A = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable_fire = 1'b0;
    logic          manual_lock = 1'b0;
    logic          act_done = 1'b0;
    logic          fault_clr = 1'b0;
    logic          act_req;
    logic          busy;
    logic          fault;
    logic [2:0]    fault_code;
    logic [CW-1:0] cmd_count;

    int checks = 0;
    int failures = 0;

    // Model: request age (cycles act_req has been high), holdoff cycles left,
    // latched fault cause (0 = not faulted), accepted pulses, previous inputs.
    int m_req_age;
    int m_hold_left;
    int m_code;
    int m_count;
    bit m_last_ef;
    bit m_last_lock;

    fire_pulse_monitor #(
        .HOLDOFF_CYCLES (H),
        .ACK_TIMEOUT    (A),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_fire (enable_fire),
        .manual_lock (manual_lock),
        .act_done    (act_done),
        .fault_clr   (fault_clr),
        .act_req     (act_req),
        .busy        (busy),
        .fault       (fault),
        .fault_code  (fault_code),
        .cmd_count   (cmd_count)
    );

    always #5 clk = ~clk;

    function automatic int exp_cnt(input int n);
`ifdef FIRE_MON_COUNTER_EN
        return n % (1 << CW);
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req_age   = 0;
        m_hold_left = 0;
        m_code      = 0;
        m_count     = 0;
        m_last_ef   = 1'b0;
        m_last_lock = 1'b0;
    endtask

    task automatic model_step();
        bit ef, lk, dn, cl, in_req, in_hold;
        int code;
        ef = enable_fire;
        lk = manual_lock;
        dn = act_done;
        cl = fault_clr;
        if (m_code != 0) begin
            if (cl && !ef && !lk) m_code = 0;
        end else begin
            in_req  = (m_req_age > 0);
            in_hold = (m_hold_left > 0);
            code = 0;
            if (in_req && lk && !m_last_lock)        code = 6;
            else if (ef && lk)                       code = 1;
            else if (ef && m_last_ef)                code = 2;
            else if (ef && (in_req || in_hold))      code = 3;
            else if (in_req && m_req_age == A && !dn) code = 4;
            else if (dn && !in_req)                  code = 5;
            if (code != 0) begin
                m_code      = code;
                m_req_age   = 0;
                m_hold_left = 0;
            end else if (in_req) begin
                if (dn) begin
                    m_req_age   = 0;
                    m_hold_left = H;
                end else begin
                    m_req_age++;
                end
            end else if (in_hold) begin
                m_hold_left--;
            end else if (ef) begin
                m_req_age = 1;
                m_count++;
            end
        end
        m_last_ef   = ef;
        m_last_lock = lk;
    endtask

    task automatic check_model();
        chk("act_req", act_req, (m_req_age > 0));
        chk("busy", busy, (m_req_age > 0 || m_hold_left > 0));
        chk("fault", fault, (m_code != 0));
        chk("fault_code", fault_code, m_code);
        chk("cmd_count", cmd_count, exp_cnt(m_count));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic handshake();
        enable_fire = 1'b1;
        tick();
        enable_fire = 1'b0;
        act_done = 1'b1;
        tick();
        act_done = 1'b0;
        repeat (H) tick();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_act_req", act_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_code", fault_code, 0);
        chk("rst_cnt", cmd_count, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Legal pulse, done on the second request cycle, full holdoff.
        enable_fire = 1'b1;
        tick();
        enable_fire = 1'b0;
        chk("t1_req_rise", act_req, 1);
        tick();
        act_done = 1'b1;
        tick();
        act_done = 1'b0;
        chk("t1_req_drop", act_req, 0);
        repeat (H - 1) tick();
        chk("t1_busy_last", busy, 1);
        tick();
        chk("t1_busy_low", busy, 0);
        chk("t1_cnt", cmd_count, exp_cnt(1));

        // Pulse on the third holdoff cycle.
        enable_fire = 1'b1;
        tick();
        enable_fire = 1'b0;
        act_done = 1'b1;
        tick();
        act_done = 1'b0;
        repeat (2) tick();
        enable_fire = 1'b1;
        tick();
        enable_fire = 1'b0;
        chk("t2_fault", fault, 1);
        chk("t2_code", fault_code, 3);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("t2_clr_fault", fault, 0);
        chk("t2_clr_code", fault_code, 0);
        chk("t2_cnt", cmd_count, exp_cnt(2));

        // Two-cycle enable_fire.
        enable_fire = 1'b1;
        tick();
        chk("t3_glitch", act_req, 1);
        tick();
        enable_fire = 1'b0;
        chk("t3_req_low", act_req, 0);
        chk("t3_code", fault_code, 2);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;

        // Request never acknowledged.
        enable_fire = 1'b1;
        tick();
        enable_fire = 1'b0;
        repeat (A - 1) tick();
        chk("t4_req_last", act_req, 1);
        tick();
        chk("t4_code", fault_code, 4);
        chk("t4_req_low", act_req, 0);
        tick();
        chk("t4_req_stays_low", act_req, 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;

        // Lock rise and pulse together during REQ, then a done while faulted.
        enable_fire = 1'b1;
        tick();
        enable_fire = 1'b0;
        tick();
        manual_lock = 1'b1;
        enable_fire = 1'b1;
        tick();
        manual_lock = 1'b0;
        enable_fire = 1'b0;
        chk("t5_code", fault_code, 6);
        act_done = 1'b1;
        tick();
        act_done = 1'b0;
        chk("t5_code_held", fault_code, 6);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("t5_clr", fault, 0);

        // Asynchronous reset in the middle of a request.
        enable_fire = 1'b1;
        tick();
        enable_fire = 1'b0;
        chk("t6_req_before", act_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_act_req", act_req, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_fault", fault, 0);
        chk("t6_async_code", fault_code, 0);
        chk("t6_async_cnt", cmd_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        tick();

        // Counter wrap.
        for (int i = 0; i < 17; i++) handshake();
        chk("t7_wrap", cmd_count, exp_cnt(17));

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            enable_fire = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) manual_lock = ~manual_lock;
            act_done  = ($urandom_range(0, 3) == 0);
            fault_clr = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
